// File: rtl/alu_seq.sv
// Registered N-bit ALU with status flags, iterative unsigned shift-add multiply
// and valid/ready handshakes on input and output; one operation in flight.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             neg,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               cout_q;
    logic               zero_q;
    logic               ovf_q;
    logic               neg_q;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic [WIDTH:0]   mul_add;
    logic             mul_last;

    // Handshake: a word moves on in_valid && in_ready (input side) and on
    // out_valid && out_ready (output side); both ready/valid come from state only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign dbg_state = state_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign neg       = neg_q;

    // op[2] selects the inverted b path; the compares force carry-in to 1.
    always_comb begin
        b_eff    = op[2] ? ~b : b;
        c_eff    = (op[2] & op[0]) ? 1'b1 : cin;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
        sum_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = sum_ovf;
            end
            OP_SLTU: begin
                alu_res  = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
                alu_cout = sum[WIDTH];
            end
            OP_SLT: begin
                alu_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
                alu_cout = sum[WIDTH];
            end
            default: ;
        endcase
    end

    // One shift-add step: add the multiplicand into the high half when the
    // multiplier LSB is set, then shift the whole product right with the carry.
    always_comb begin
        mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_d   = {mul_add, prod_q[WIDTH-1:1]};
        mul_last = (cnt_q == CW'(WIDTH-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            mcand_q <= a;
                            prod_q  <= {{WIDTH{1'b0}}, b};
                            cnt_q   <= '0;
                            state_q <= S_MUL;
                        end else begin
                            result_q    <= alu_res;
                            result_hi_q <= '0;
                            cout_q      <= alu_cout;
                            zero_q      <= (alu_res == '0);
                            ovf_q       <= alu_ovf;
                            neg_q       <= alu_res[WIDTH-1];
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (mul_last) begin
                        result_q    <= prod_d[WIDTH-1:0];
                        result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        cout_q      <= |prod_d[2*WIDTH-1:WIDTH];
                        zero_q      <= (prod_d[WIDTH-1:0] == '0);
                        ovf_q       <= 1'b0;
                        neg_q       <= prod_d[WIDTH-1];
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH = 8: logic ops, add/sub,
// compares, multiply latency, backpressure and reset during a multiply.
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         cout;
  logic         zero;
  logic         ovf;
  logic         neg;
  logic [1:0]   dbg_state;

  int n_cmp;
  int n_err;
  logic ready_seen_busy;
  logic [19:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .cout      (cout),
    .zero      (zero),
    .ovf       (ovf),
    .neg       (neg),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard
  task automatic expect_res(input logic [7:0] hi, input logic [7:0] res,
                            input logic c, input logic z, input logic v, input logic n);
    exp_q.push_back({hi, res, c, z, v, n});
  endtask

  task automatic check_result(input string tag);
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_queue: got empty expected queue required an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, 16'(out_valid), 16'd1);
      check_eq({tag, "_hi"},    16'(result_hi), 16'(e[19:12]));
      check_eq({tag, "_res"},   16'(result),    16'(e[11:4]));
      check_eq({tag, "_flags"}, 16'({cout, zero, ovf, neg}), 16'(e[3:0]));
    end
  endtask

  // drivers
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic c, output int lat);
    int waited;
    @(negedge clk);
    op = o; a = x; b = y; cin = c; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check_eq("accept_timeout", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    ready_seen_busy = in_ready;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      ready_seen_busy = ready_seen_busy | in_ready;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("drain_idle", 16'(in_ready), 16'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [7:0] x,
                     input logic [7:0] y, input logic c,
                     input logic [7:0] ehi, input logic [7:0] eres,
                     input logic ec, input logic ez, input logic ev, input logic en,
                     input int elat);
    int lat;
    expect_res(ehi, eres, ec, ez, ev, en);
    send(o, x, y, c, lat);
    check_eq({tag, "_lat"}, 16'(lat), 16'(elat));
    check_eq({tag, "_busy_ready"}, 16'(ready_seen_busy), 16'd0);
    check_result(tag);
    drain();
  endtask

  initial begin
    logic seen;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = OP_AND;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready",  16'(in_ready), 16'd1);
    check_eq("rst_out_valid", 16'(out_valid), 16'd0);
    check_eq("rst_result",    16'({result_hi, result}), 16'h0000);
    check_eq("rst_flags",     16'({cout, zero, ovf, neg}), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // logic ops
    run("and",  OP_AND,  8'hF0, 8'h3C, 1'b0, 8'h00, 8'h30, 0, 0, 0, 0, 1);
    run("or",   OP_OR,   8'hF0, 8'h3C, 1'b1, 8'h00, 8'hFC, 0, 0, 0, 1, 1);
    run("nor",  OP_NOR,  8'hF0, 8'h3C, 1'b0, 8'h00, 8'h03, 0, 0, 0, 0, 1);
    // add
    run("add_wrap", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 1);
    run("add_ovf",  OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h80, 0, 0, 1, 1, 1);
    run("add_cin",  OP_ADD, 8'h01, 8'h01, 1'b1, 8'h00, 8'h03, 0, 0, 0, 0, 1);
    // sub and compares (compares ignore cin)
    run("sub_neg",  OP_SUB,  8'h05, 8'h07, 1'b1, 8'h00, 8'hFE, 0, 0, 0, 1, 1);
    run("sub_ovf",  OP_SUB,  8'h80, 8'h01, 1'b1, 8'h00, 8'h7F, 1, 0, 1, 0, 1);
    run("slt_lt",   OP_SLT,  8'h80, 8'h01, 1'b0, 8'h00, 8'h01, 1, 0, 0, 0, 1);
    run("sltu_ge",  OP_SLTU, 8'h80, 8'h01, 1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 1);
    run("slt_eq",   OP_SLT,  8'h03, 8'h03, 1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 1);
    run("sltu_lt",  OP_SLTU, 8'h01, 8'h80, 1'b1, 8'h00, 8'h01, 0, 0, 0, 0, 1);
    // multiply
    run("mul_ff",   OP_MUL, 8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, 1, 0, 0, 0, 9);
    run("mul_zero", OP_MUL, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1, 0, 0, 9);
    run("mul_mid",  OP_MUL, 8'h0D, 8'h0B, 1'b0, 8'h00, 8'h8F, 0, 0, 0, 1, 9);

    // backpressure: hold out_ready low while a new operation is offered
    begin
      int lat;
      expect_res(8'h00, 8'h46, 0, 0, 0, 0);
      send(OP_ADD, 8'h12, 8'h34, 1'b0, lat);
      check_result("bp_first");
      @(negedge clk);
      op = OP_ADD; a = 8'h40; b = 8'h41; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1;
        check_eq("bp_hold_res",   16'(result), 16'h0046);
        check_eq("bp_hold_ready", 16'(in_ready), 16'd0);
        check_eq("bp_hold_valid", 16'(out_valid), 16'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_release_idle", 16'(in_ready), 16'd1);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      expect_res(8'h00, 8'h81, 0, 0, 1, 1);
      check_result("bp_second");
      drain();
    end

    // reset in the 4th multiply cycle
    @(negedge clk);
    op = OP_MUL; a = 8'hFF; b = 8'hFF; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("rmul_state", 16'(dbg_state), 16'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rmul_out_valid", 16'(out_valid), 16'd0);
    check_eq("rmul_in_ready",  16'(in_ready), 16'd1);
    check_eq("rmul_result",    16'({result_hi, result}), 16'h0000);
    check_eq("rmul_flags",     16'({cout, zero, ovf, neg}), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check_eq("rmul_no_stale", 16'(seen), 16'd0);
    check_eq("rmul_ready_after", 16'(in_ready), 16'd1);
    run("post_rst_add", OP_ADD, 8'h02, 8'h03, 1'b0, 8'h00, 8'h05, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
